aes_dec_scheduler: RTL and testbench

Sequencer for the AES-128 decryption datapath. It walks the ciphertext/key ROM address (`pc_o`) over a batch of blocks. For each block it drives the forward key expansion up to the round-10 key, then the 10 inverse rounds with inverse key stepping. It pulses `finish_o` with a write-ready handshake so the plaintext RAM captures each result. It sits between the top-level start logic and the `inv_*`, `addroundkey`, `key_expansion`, `MUX2_128` and `algorithm_reg` datapath.

---
 rtl/aes_dec_scheduler_pkg.sv | 71 +++++++
 rtl/aes_dec_scheduler_if.sv | 53 +++++
 rtl/aes_dec_scheduler.sv | 106 ++++++++++
 tb/tb_aes_dec_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_scheduler_pkg.sv
// Shared constants, state encodings and strobe decode for the AES-128
// decryption sequencer.
package aes_dec_scheduler_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int MEMORY_SIZE    = 16;
    localparam int NUM_ROUNDS     = 10;
    localparam int KEY_FWD_CYCLES = 10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_KEYFWD = 3'd2;
    localparam logic [2:0] S_INIT   = 3'd3;
    localparam logic [2:0] S_ROUND  = 3'd4;
    localparam logic [2:0] S_FINAL  = 3'd5;
    localparam logic [2:0] S_WRITE  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    typedef struct packed {
        logic busy;
        logic done;
        logic stateLoad;
        logic keyLoad;
        logic keyStep;
        logic keyInv;
        logic arkEn;
        logic mixBypass;
        logic finish;
    } ctrl_t;

    // Every datapath strobe is a pure function of the registered state, so
    // no input ever reaches an output combinationally.
    function automatic ctrl_t decodeCtrl(input logic [2:0] state);
        ctrl_t c;
        c = '0;
        case (state)
            S_LOAD: begin
                c.busy      = 1'b1;
                c.stateLoad = 1'b1;
                c.keyLoad   = 1'b1;
            end
            S_KEYFWD: begin
                c.busy    = 1'b1;
                c.keyStep = 1'b1;
            end
            S_INIT, S_ROUND: begin
                c.busy    = 1'b1;
                c.keyStep = 1'b1;
                c.keyInv  = 1'b1;
                c.arkEn   = 1'b1;
            end
            S_FINAL: begin
                c.busy      = 1'b1;
                c.arkEn     = 1'b1;
                c.mixBypass = 1'b1;
            end
            S_WRITE: begin
                c.busy   = 1'b1;
                c.finish = 1'b1;
            end
            S_DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_dec_scheduler_if.sv
// Control/handshake bundle between the decryption sequencer (master) and the
// start logic, plaintext RAM and datapath (slave).
interface aes_dec_scheduler_if #(
    parameter int ADDR_WIDTH = 4
);

    logic                  start_i;
    logic                  wr_ready_i;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  state_load_o;
    logic                  key_load_o;
    logic                  key_step_o;
    logic                  key_inv_o;
    logic [3:0]            round_o;
    logic                  ark_en_o;
    logic                  mix_bypass_o;
    logic                  finish_o;

    modport master (
        input  start_i,
        input  wr_ready_i,
        output busy_o,
        output done_o,
        output pc_o,
        output state_load_o,
        output key_load_o,
        output key_step_o,
        output key_inv_o,
        output round_o,
        output ark_en_o,
        output mix_bypass_o,
        output finish_o
    );

    modport slave (
        output start_i,
        output wr_ready_i,
        input  busy_o,
        input  done_o,
        input  pc_o,
        input  state_load_o,
        input  key_load_o,
        input  key_step_o,
        input  key_inv_o,
        input  round_o,
        input  ark_en_o,
        input  mix_bypass_o,
        input  finish_o
    );

endinterface

// File: rtl/aes_dec_scheduler.sv
// Batch sequencer for the AES-128 decryption datapath: walks pc over the
// ciphertext blocks, runs forward key expansion to k10, then the ten inverse
// rounds, and hands each plaintext to the RAM through a ready handshake.
module aes_dec_scheduler
    import aes_dec_scheduler_pkg::*;
#(
    parameter int NUM_BLOCKS = MEMORY_SIZE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    aes_dec_scheduler_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC   = ADDR_WIDTH'(NUM_BLOCKS - 1);
    localparam logic [3:0]            FWD_LAST  = 4'(KEY_FWD_CYCLES);
    localparam logic [3:0]            INV_FIRST = 4'(NUM_ROUNDS - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]            round_q, round_d;
    ctrl_t                 ctrl;

    // Next-state logic: the round counter doubles as the KEYFWD/ROUND cycle
    // counter, and pc only moves on a start or on a completed write.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        round_d = round_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    state_d = S_LOAD;
                    pc_d    = '0;
                end
            end
            S_LOAD: begin
                round_d = 4'd1;
                state_d = S_KEYFWD;
            end
            S_KEYFWD: begin
                if (round_q == FWD_LAST) begin
                    state_d = S_INIT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_INIT: begin
                round_d = INV_FIRST;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (round_q == 4'd1) begin
                    round_d = 4'd0;
                    state_d = S_FINAL;
                end else begin
                    round_d = round_q - 4'd1;
                end
            end
            S_FINAL: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.wr_ready_i) begin
                    if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pc and round registers; reset drops any block in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            round_q <= round_d;
        end
    end

    assign ctrl = decodeCtrl(state_q);

    assign bus.busy_o       = ctrl.busy;
    assign bus.done_o       = ctrl.done;
    assign bus.pc_o         = pc_q;
    assign bus.state_load_o = ctrl.stateLoad;
    assign bus.key_load_o   = ctrl.keyLoad;
    assign bus.key_step_o   = ctrl.keyStep;
    assign bus.key_inv_o    = ctrl.keyInv;
    assign bus.round_o      = round_q;
    assign bus.ark_en_o     = ctrl.arkEn;
    assign bus.mix_bypass_o = ctrl.mixBypass;
    assign bus.finish_o     = ctrl.finish;

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Self-checking bench for aes_dec_scheduler: a three-block instance for the
// main scenarios and a one-block instance for the single-block batch.
module tb_aes_dec_scheduler;

    localparam int AW = 4;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rstN;

    int vectors = 0;
    int misses  = 0;

    int expWrites[$];
    int gotWrites[$];
    int expOne[$];
    int gotOne[$];
    logic [9:0] expTrace[$];

    aes_dec_scheduler_if #(.ADDR_WIDTH(AW)) bus ();
    aes_dec_scheduler_if #(.ADDR_WIDTH(AW)) busOne ();

    aes_dec_scheduler #(.NUM_BLOCKS(NB), .ADDR_WIDTH(AW)) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (bus)
    );

    aes_dec_scheduler #(.NUM_BLOCKS(1), .ADDR_WIDTH(AW)) dutOne (
        .clk_i (clk),
        .rst_ni(rstN),
        .bus   (busOne)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Record every RAM write as it happens, i.e. at the edge where finish and ready are both high.
    always @(posedge clk) begin
        if (rstN && bus.finish_o && bus.wr_ready_i) gotWrites.push_back(int'(bus.pc_o));
        if (rstN && busOne.finish_o && busOne.wr_ready_i) gotOne.push_back(int'(busOne.pc_o));
    end

    function automatic logic [16:0] snapMain();
        return {bus.busy_o, bus.done_o, bus.state_load_o, bus.key_load_o, bus.key_step_o,
                bus.key_inv_o, bus.ark_en_o, bus.mix_bypass_o, bus.finish_o, bus.round_o, bus.pc_o};
    endfunction

    function automatic logic [16:0] snapOne();
        return {busOne.busy_o, busOne.done_o, busOne.state_load_o, busOne.key_load_o, busOne.key_step_o,
                busOne.key_inv_o, busOne.ark_en_o, busOne.mix_bypass_o, busOne.finish_o, busOne.round_o,
                busOne.pc_o};
    endfunction

    task automatic test_reset();
        rstN = 1'b0;
        bus.start_i = 1'b1;
        bus.wr_ready_i = 1'b1;
        busOne.start_i = 1'b0;
        busOne.wr_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (snapMain() !== 17'd0) begin
            misses++;
            $display("[TB] FAIL reset_outputs: got %h want %h", snapMain(), 17'd0);
        end
        vectors++;
        if (snapOne() !== 17'd0) begin
            misses++;
            $display("[TB] FAIL reset_outputs_one: got %h want %h", snapOne(), 17'd0);
        end
        rstN = 1'b1;
        bus.start_i = 1'b0;
        bus.wr_ready_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (snapMain() !== 17'd0) begin
            misses++;
            $display("[TB] FAIL idle_hold: got %h want %h", snapMain(), 17'd0);
        end
    endtask

    task automatic test_strobe_trace();
        logic [9:0] got;
        logic [9:0] want;
        bus.start_i = 1'b1;
        expWrites.push_back(0);
        @(negedge clk);
        bus.start_i = 1'b0;
        vectors++;
        if (snapMain() !== {1'b1, 1'b0, 6'b110000, 1'b0, 4'd0, 4'd0}) begin
            misses++;
            $display("[TB] FAIL load_strobes: got %h want %h", snapMain(),
                     {1'b1, 1'b0, 6'b110000, 1'b0, 4'd0, 4'd0});
        end
        // round, key_step, key_inv, ark_en, mix_bypass, finish
        for (int r = 1; r <= 10; r++) expTrace.push_back({4'(r), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        expTrace.push_back({4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        for (int r = 9; r >= 1; r--) expTrace.push_back({4'(r), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        expTrace.push_back({4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            want = expTrace.pop_front();
            got = {bus.round_o, bus.key_step_o, bus.key_inv_o, bus.ark_en_o, bus.mix_bypass_o,
                   bus.finish_o, bus.state_load_o};
            vectors++;
            if (got !== want) begin
                misses++;
                $display("[TB] FAIL trace_cycle_%0d: got %b want %b", k, got, want);
            end
        end
    endtask

    task automatic test_write_stall();
        int got;
        int want;
        @(negedge clk);
        vectors++;
        if (snapMain() !== {1'b1, 1'b0, 6'b000000, 1'b1, 4'd0, 4'd0}) begin
            misses++;
            $display("[TB] FAIL write_entry: got %h want %h", snapMain(),
                     {1'b1, 1'b0, 6'b000000, 1'b1, 4'd0, 4'd0});
        end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (k == 6) bus.wr_ready_i = 1'b1;
            vectors++;
            if ({bus.finish_o, bus.pc_o} !== {1'b1, 4'd0}) begin
                misses++;
                $display("[TB] FAIL stall_cycle_%0d: got finish=%b pc=%0d want finish=1 pc=0",
                         k, bus.finish_o, bus.pc_o);
            end
        end
        @(negedge clk);
        vectors++;
        if ({bus.state_load_o, bus.finish_o, bus.pc_o} !== {1'b1, 1'b0, 4'd1}) begin
            misses++;
            $display("[TB] FAIL stall_release: got load=%b finish=%b pc=%0d want load=1 finish=0 pc=1",
                     bus.state_load_o, bus.finish_o, bus.pc_o);
        end
        vectors++;
        if (gotWrites.size() !== expWrites.size()) begin
            misses++;
            $display("[TB] FAIL stall_write_count: got %0d want %0d", gotWrites.size(), expWrites.size());
        end
        while (gotWrites.size() > 0 && expWrites.size() > 0) begin
            got = gotWrites.pop_front();
            want = expWrites.pop_front();
            vectors++;
            if (got !== want) begin
                misses++;
                $display("[TB] FAIL stall_write_pc: got %0d want %0d", got, want);
            end
        end
        gotWrites.delete();
        expWrites.delete();
    endtask

    task automatic test_back_to_back();
        int got;
        int want;
        logic [5:0] seen;
        logic [5:0] req;
        expWrites.push_back(1);
        expWrites.push_back(2);
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            bus.start_i = (k == 5 || k == 30 || k == 44);
            seen = {bus.busy_o, bus.done_o, bus.pc_o};
            req = {(k < 46), (k == 46), ((k <= 22) ? 4'd1 : 4'd2)};
            vectors++;
            if (seen !== req) begin
                misses++;
                $display("[TB] FAIL b2b_cycle_%0d: got busy/done/pc %b want %b", k, seen, req);
            end
        end
        bus.start_i = 1'b0;
        vectors++;
        if (gotWrites.size() !== expWrites.size()) begin
            misses++;
            $display("[TB] FAIL b2b_write_count: got %0d want %0d", gotWrites.size(), expWrites.size());
        end
        while (gotWrites.size() > 0 && expWrites.size() > 0) begin
            got = gotWrites.pop_front();
            want = expWrites.pop_front();
            vectors++;
            if (got !== want) begin
                misses++;
                $display("[TB] FAIL b2b_write_pc: got %0d want %0d", got, want);
            end
        end
        gotWrites.delete();
        expWrites.delete();
    endtask

    task automatic test_restart();
        int got;
        int want;
        int doneAt;
        bus.wr_ready_i = 1'b1;
        bus.start_i = 1'b1;
        for (int i = 0; i < NB; i++) expWrites.push_back(i);
        @(negedge clk);
        bus.start_i = 1'b0;
        vectors++;
        if ({bus.state_load_o, bus.done_o, bus.pc_o} !== {1'b1, 1'b0, 4'd0}) begin
            misses++;
            $display("[TB] FAIL restart_load: got load=%b done=%b pc=%0d want load=1 done=0 pc=0",
                     bus.state_load_o, bus.done_o, bus.pc_o);
        end
        doneAt = -1;
        for (int k = 1; k <= 200 && doneAt < 0; k++) begin
            @(negedge clk);
            if (bus.done_o) doneAt = k;
        end
        vectors++;
        if (doneAt !== 23 * NB) begin
            misses++;
            $display("[TB] FAIL restart_done_latency: got %0d want %0d", doneAt, 23 * NB);
        end
        vectors++;
        if (gotWrites.size() !== expWrites.size()) begin
            misses++;
            $display("[TB] FAIL restart_write_count: got %0d want %0d", gotWrites.size(), expWrites.size());
        end
        while (gotWrites.size() > 0 && expWrites.size() > 0) begin
            got = gotWrites.pop_front();
            want = expWrites.pop_front();
            vectors++;
            if (got !== want) begin
                misses++;
                $display("[TB] FAIL restart_write_pc: got %0d want %0d", got, want);
            end
        end
        gotWrites.delete();
        expWrites.delete();
    endtask

    task automatic test_reset_mid();
        int got;
        int want;
        bus.start_i = 1'b1;
        expWrites.push_back(0);
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (38) @(negedge clk);
        vectors++;
        if ({bus.pc_o, bus.ark_en_o, bus.key_inv_o, bus.mix_bypass_o} !== {4'd1, 1'b1, 1'b1, 1'b0}) begin
            misses++;
            $display("[TB] FAIL midreset_in_round: got pc=%0d ark=%b inv=%b byp=%b want pc=1 ark=1 inv=1 byp=0",
                     bus.pc_o, bus.ark_en_o, bus.key_inv_o, bus.mix_bypass_o);
        end
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        vectors++;
        if (snapMain() !== 17'd0) begin
            misses++;
            $display("[TB] FAIL midreset_outputs: got %h want %h", snapMain(), 17'd0);
        end
        repeat (30) @(negedge clk);
        vectors++;
        if (snapMain() !== 17'd0) begin
            misses++;
            $display("[TB] FAIL midreset_stays_idle: got %h want %h", snapMain(), 17'd0);
        end
        vectors++;
        if (gotWrites.size() !== expWrites.size()) begin
            misses++;
            $display("[TB] FAIL midreset_write_count: got %0d want %0d", gotWrites.size(), expWrites.size());
        end
        while (gotWrites.size() > 0 && expWrites.size() > 0) begin
            got = gotWrites.pop_front();
            want = expWrites.pop_front();
            vectors++;
            if (got !== want) begin
                misses++;
                $display("[TB] FAIL midreset_write_pc: got %0d want %0d", got, want);
            end
        end
        gotWrites.delete();
        expWrites.delete();
    endtask

    task automatic test_single_block();
        int got;
        int want;
        int doneAt;
        busOne.wr_ready_i = 1'b1;
        busOne.start_i = 1'b1;
        expOne.push_back(0);
        @(negedge clk);
        busOne.start_i = 1'b0;
        doneAt = -1;
        for (int k = 1; k <= 100 && doneAt < 0; k++) begin
            @(negedge clk);
            if (busOne.done_o) doneAt = k;
        end
        vectors++;
        if (doneAt !== 23) begin
            misses++;
            $display("[TB] FAIL single_done_latency: got %0d want 23", doneAt);
        end
        vectors++;
        if ({busOne.busy_o, busOne.finish_o, busOne.pc_o} !== {1'b0, 1'b0, 4'd0}) begin
            misses++;
            $display("[TB] FAIL single_done_state: got busy=%b finish=%b pc=%0d want 0 0 0",
                     busOne.busy_o, busOne.finish_o, busOne.pc_o);
        end
        vectors++;
        if (gotOne.size() !== expOne.size()) begin
            misses++;
            $display("[TB] FAIL single_write_count: got %0d want %0d", gotOne.size(), expOne.size());
        end
        while (gotOne.size() > 0 && expOne.size() > 0) begin
            got = gotOne.pop_front();
            want = expOne.pop_front();
            vectors++;
            if (got !== want) begin
                misses++;
                $display("[TB] FAIL single_write_pc: got %0d want %0d", got, want);
            end
        end
    endtask

    // Overall time limit so a stuck run still terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_strobe_trace();
        test_write_stall();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        test_single_block();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
